// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, datapath widths and the bubble word.
package instr_fetch_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP = '0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    link;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// Single-entry skid buffer behind the fetch output register.
// Clear wins over load so a redirect always empties the buffer.
module fetch_skid_reg
   import instr_fetch_pkg::*;
(
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t data_o,
   output logic         full_o
);

   fetch_entry_t data_q, data_d;
   logic         full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (clear_i) begin
         data_d = '0;
         full_d = 1'b0;
      end else if (load_i) begin
         data_d = data_i;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, request FSM, output entry and skid.
// DRAIN waits out a request that a redirect made stale.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 64'h0,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               PC_Write,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [PC_W-1:0]    PC_out_out,
   output logic [PC_W-1:0]    PC_branch_link_out,
   output logic               valid_out
);

   localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   fetch_entry_t    out_q, out_d;
   logic            valid_q, valid_d;

   logic            hs;
   logic            can_accept;
   fetch_entry_t    capture;
   logic            skid_load;
   logic            skid_clr;
   fetch_entry_t    skid_data;
   logic            skid_full;

   assign hs         = imem_req & imem_ready;
   assign can_accept = ~valid_q | PC_Write;
   assign capture    = '{instr: imem_rdata,
                         pc:    pc_q,
                         link:  pc_q + STEP};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH: begin
            if (branch_taken && !hs) begin
               state_d = DRAIN;
            end else if (!branch_taken && hs && !can_accept) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (branch_taken || PC_Write) begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (hs) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      imem_req  = (state_q != HOLD);
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      out_d     = out_q;
      valid_d   = valid_q;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (branch_taken) begin
               out_d   = '0;
               valid_d = 1'b0;
               if (hs) begin
                  pc_d = branch_target;
               end else begin
                  tgt_d = branch_target;
               end
            end else if (hs) begin
               pc_d = pc_q + STEP;
               if (can_accept) begin
                  out_d   = capture;
                  valid_d = 1'b1;
               end else begin
                  skid_load = 1'b1;
               end
            end else if (PC_Write) begin
               out_d   = '0;
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               skid_clr = 1'b1;
               out_d    = '0;
               valid_d  = 1'b0;
               pc_d     = branch_target;
            end else if (PC_Write) begin
               skid_clr = 1'b1;
               out_d    = skid_data;
               valid_d  = skid_full;
            end
         end
         DRAIN: begin
            // a late redirect overrides the saved one
            if (hs) begin
               pc_d = branch_taken ? branch_target : tgt_q;
            end else if (branch_taken) begin
               tgt_d = branch_target;
            end
         end
         default: begin
            out_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   fetch_skid_reg u_skid (
      .clock_i (clock),
      .reset_i (reset),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .data_i  (capture),
      .data_o  (skid_data),
      .full_o  (skid_full)
   );

   assign imem_addr          = pc_q;
   assign instruction_out    = valid_q ? out_q.instr : NOP;
   assign PC_out_out         = out_q.pc;
   assign PC_branch_link_out = out_q.link;
   assign valid_out          = valid_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded by reset.
REQ-002 Parameter PC_STEP, default 4, byte increment between sequential fetches.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 PC_Write  in  1  hazard-unit advance enable; 1 = downstream consumes the output entry this edge.
REQ-006 branch_taken  in  1  redirect request; overrides PC_Write.
REQ-007 branch_target  in  64  redirect address, sampled when branch_taken=1.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  64  request address; equals PC.
REQ-010 imem_ready  in  1  response strobe; a handshake completes on an edge where imem_req and imem_ready are both 1.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ready.
REQ-012 instruction_out  out  32  fetched word; 32'b0 when valid_out=0.
REQ-013 PC_out_out  out  64  address of instruction_out.
REQ-014 PC_branch_link_out  out  64  PC_out_out + PC_STEP (link value).
REQ-015 valid_out  out  1  output entry holds a real instruction.

Function
REQ-016 FSM states: FETCH (imem_req=1), HOLD (imem_req=0, skid full), DRAIN (imem_req=1, response will be discarded).
REQ-017 Once imem_req=1, imem_addr shall stay constant until the handshake completes.
REQ-018 Storage: one output entry (drives outputs, registered) plus one skid entry; capture = {imem_rdata, PC, PC+PC_STEP}.
REQ-019 Output entry is consumed at an edge where PC_Write=1; it may accept new data when valid_out=0 or it is being consumed.
REQ-020 FETCH, handshake, no redirect, output entry can accept: load output entry with capture, valid_out<=1, PC<=PC+PC_STEP, stay FETCH.
REQ-021 FETCH, handshake, no redirect, output entry full and PC_Write=0: load skid, PC<=PC+PC_STEP, go HOLD.
REQ-022 FETCH, no handshake, PC_Write=1: valid_out<=0 (bubble); PC_Write=0: output entry holds.
REQ-023 HOLD, PC_Write=1: output entry<=skid, skid cleared, go FETCH; PC_Write=0: all state holds.
REQ-024 branch_taken in FETCH with handshake: discard response, valid_out<=0, PC<=branch_target, stay FETCH.
REQ-025 branch_taken in FETCH without handshake: valid_out<=0, save branch_target, go DRAIN.
REQ-026 branch_taken in HOLD: clear skid and valid_out, PC<=branch_target, go FETCH.
REQ-027 DRAIN: keep imem_addr; on handshake discard data, PC<=saved target, go FETCH; branch_taken in DRAIN replaces saved target.
REQ-028 No capture into either entry in DRAIN or in any cycle with branch_taken=1.
REQ-029 PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-030 Fetch-to-output latency: output valid on the edge completing the handshake; peak throughput one instruction per cycle.

Reset
REQ-031 reset shall immediately force PC=RESET_PC, state=FETCH, valid_out=0, skid cleared, saved target=0, instruction_out=0, PC_out_out=0, PC_branch_link_out=0.
REQ-032 reset mid-transaction abandons the outstanding request; first request after release uses RESET_PC.

Structure
REQ-033 Shared package holds the FSM state enum, PC width (64), instruction width (32), and NOP/bubble encoding 32'b0.
REQ-034 Skid entry plus its load/unload control is one sub-module, fetch_skid_reg; the FSM and PC stay in instr_fetch.

Verification
REQ-035 Reset release, imem_ready=1 always, PC_Write=1 -> imem_addr 0,4,8,...; outputs (instr,0,4),(instr,4,8) on consecutive cycles.
REQ-036 Output valid at PC 8, PC_Write=0 for 3 cycles with ready=1 -> skid holds PC 12, imem_req=0 in HOLD; on PC_Write=1 output PC 12 then fetch resumes at 16.
REQ-037 imem_ready=0 at addr 0x20, branch_taken with target 0x100 -> imem_addr stays 0x20 until ready, response dropped, next imem_addr 0x100, no valid_out for 0x20.
REQ-038 branch_taken target 0x200 coincident with handshake and PC_Write=0 -> valid_out=0 next cycle, next imem_addr 0x200.
REQ-039 Redirect to 0xFFFF_FFFF_FFFF_FFFC -> PC_branch_link_out=0, next imem_addr 0.
REQ-040 reset asserted in DRAIN and in HOLD -> outputs zero asynchronously, first request at RESET_PC after release.
